// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a register value to byte/halfword/word, lane-aligns it
// onto a 32-bit word-addressed write port with byte enables, and issues one or two
// write beats through a valid/ready handshake.
// Optional feature macro: MISALIGN_SPLIT_EN (misaligned stores are split across two
// words instead of being rejected with err).
module store_narrow_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t            state, state_nxt;
  logic              req_ready_nxt, mem_valid_nxt, done_nxt, err_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [31:0]       mem_wdata_nxt;
  logic [3:0]        mem_be_nxt;

  logic [1:0]        off_c;
  logic              legal_c;
  logic [31:0]       lo_wdata_c;
  logic [3:0]        lo_be_c;
  logic [ADDR_W-1:0] aligned_c;

`ifdef MISALIGN_SPLIT_EN
  logic [63:0] n_c, wide_c;
  logic [7:0]  be_base_c, be8_c;
  logic [31:0] hi_wdata, hi_wdata_nxt, hi_wdata_c;
  logic [3:0]  hi_be, hi_be_nxt, hi_be_c;

  // Narrow, zero-extend to 64 bits and shift into lane position; any offset is legal
  always_comb begin
    off_c     = req_addr[1:0];
    n_c       = 64'd0;
    be_base_c = 8'd0;
    legal_c   = 1'b1;
    case (req_size)
      SIZE_BYTE: begin n_c = 64'(req_data[7:0]);  be_base_c = 8'b0000_0001; end
      SIZE_HALF: begin n_c = 64'(req_data[15:0]); be_base_c = 8'b0000_0011; end
      SIZE_WORD: begin n_c = 64'(req_data);       be_base_c = 8'b0000_1111; end
      default:   legal_c = 1'b0;
    endcase
    wide_c     = n_c << {off_c, 3'b000};
    be8_c      = be_base_c << off_c;
    lo_wdata_c = wide_c[31:0];
    lo_be_c    = be8_c[3:0];
    hi_wdata_c = wide_c[63:32];
    hi_be_c    = be8_c[7:4];
    aligned_c  = {req_addr[ADDR_W-1:2], 2'b00};
  end
`else
  logic [31:0] n_c;
  logic [3:0]  be_base_c;

  // Narrow and shift into lane position; misaligned half/word requests are illegal
  always_comb begin
    off_c     = req_addr[1:0];
    n_c       = 32'd0;
    be_base_c = 4'd0;
    legal_c   = 1'b1;
    case (req_size)
      SIZE_BYTE: begin n_c = 32'(req_data[7:0]);  be_base_c = 4'b0001; end
      SIZE_HALF: begin
        n_c       = 32'(req_data[15:0]);
        be_base_c = 4'b0011;
        legal_c   = ~off_c[0];
      end
      SIZE_WORD: begin
        n_c       = req_data;
        be_base_c = 4'b1111;
        legal_c   = (off_c == 2'b00);
      end
      default:   legal_c = 1'b0;
    endcase
    lo_wdata_c = n_c << {off_c, 3'b000};
    lo_be_c    = be_base_c << off_c;
    aligned_c  = {req_addr[ADDR_W-1:2], 2'b00};
  end
`endif

  // Next-state and next-output logic; outputs hold unless a transition changes them
  always_comb begin
    state_nxt     = state;
    req_ready_nxt = req_ready;
    mem_valid_nxt = mem_valid;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_be_nxt    = mem_be;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    hi_wdata_nxt  = hi_wdata;
    hi_be_nxt     = hi_be;
`endif
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (legal_c) begin
            state_nxt     = BEAT0;
            req_ready_nxt = 1'b0;
            mem_valid_nxt = 1'b1;
            mem_addr_nxt  = aligned_c;
            mem_wdata_nxt = lo_wdata_c;
            mem_be_nxt    = lo_be_c;
`ifdef MISALIGN_SPLIT_EN
            hi_wdata_nxt  = hi_wdata_c;
            hi_be_nxt     = hi_be_c;
`endif
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
`ifdef MISALIGN_SPLIT_EN
          if (hi_be != 4'd0) begin
            state_nxt     = BEAT1;
            mem_addr_nxt  = mem_addr + ADDR_W'(4);
            mem_wdata_nxt = hi_wdata;
            mem_be_nxt    = hi_be;
          end else begin
            state_nxt     = IDLE;
            req_ready_nxt = 1'b1;
            mem_valid_nxt = 1'b0;
            mem_addr_nxt  = '0;
            mem_wdata_nxt = 32'd0;
            mem_be_nxt    = 4'd0;
            done_nxt      = 1'b1;
          end
`else
          state_nxt     = IDLE;
          req_ready_nxt = 1'b1;
          mem_valid_nxt = 1'b0;
          mem_addr_nxt  = '0;
          mem_wdata_nxt = 32'd0;
          mem_be_nxt    = 4'd0;
          done_nxt      = 1'b1;
`endif
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_nxt     = IDLE;
          req_ready_nxt = 1'b1;
          mem_valid_nxt = 1'b0;
          mem_addr_nxt  = '0;
          mem_wdata_nxt = 32'd0;
          mem_be_nxt    = 4'd0;
          done_nxt      = 1'b1;
        end
      end
      default: begin
        state_nxt     = IDLE;
        req_ready_nxt = 1'b1;
        mem_valid_nxt = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = 32'd0;
        mem_be_nxt    = 4'd0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      hi_wdata  <= 32'd0;
      hi_be     <= 4'd0;
`endif
    end else begin
      state     <= state_nxt;
      req_ready <= req_ready_nxt;
      mem_valid <= mem_valid_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_be    <= mem_be_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
`ifdef MISALIGN_SPLIT_EN
      hi_wdata  <= hi_wdata_nxt;
      hi_be     <= hi_be_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed, table-driven bench for store_narrow_unit; expectations follow the
// MISALIGN_SPLIT_EN setting of the build.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  store_narrow_unit #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        err;
    int          nbeats;
    logic [31:0] a0;
    logic [3:0]  b0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  b1;
    logic [31:0] w1;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] size, input logic e, input int nb,
                              input logic [31:0] a0, input logic [3:0] b0,
                              input logic [31:0] w0, input logic [31:0] a1,
                              input logic [3:0] b1, input logic [31:0] w1);
    vec_t v;
    v.addr = addr; v.data = data; v.size = size; v.err = e; v.nbeats = nb;
    v.a0 = a0; v.b0 = b0; v.w0 = w0; v.a1 = a1; v.b1 = b1; v.w1 = w1;
    return v;
  endfunction

  function automatic vec_t mk_err(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [1:0] size);
    return mk(addr, data, size, 1'b1, 0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one request with mem_ready held high and check every cycle until idle again
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    chk($sformatf("v%0d req_ready_idle", idx), 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_data  = v.data;
    req_size  = v.size;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (v.err) begin
      chk($sformatf("v%0d err_pulse", idx), 64'(err), 64'd1);
      chk($sformatf("v%0d err_no_valid", idx), 64'(mem_valid), 64'd0);
      chk($sformatf("v%0d err_no_done", idx), 64'(done), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d err_one_cycle", idx), 64'(err), 64'd0);
      chk($sformatf("v%0d err_still_no_valid", idx), 64'(mem_valid), 64'd0);
    end else begin
      chk($sformatf("v%0d no_err", idx), 64'(err), 64'd0);
      for (int b = 0; b < v.nbeats; b++) begin
        chk($sformatf("v%0d b%0d valid", idx, b), 64'(mem_valid), 64'd1);
        chk($sformatf("v%0d b%0d addr", idx, b), 64'(mem_addr), 64'(b == 0 ? v.a0 : v.a1));
        chk($sformatf("v%0d b%0d be", idx, b), 64'(mem_be), 64'(b == 0 ? v.b0 : v.b1));
        chk($sformatf("v%0d b%0d wdata", idx, b), 64'(mem_wdata), 64'(b == 0 ? v.w0 : v.w1));
        chk($sformatf("v%0d b%0d req_ready", idx, b), 64'(req_ready), 64'd0);
        chk($sformatf("v%0d b%0d no_done", idx, b), 64'(done), 64'd0);
        @(negedge clk);
      end
      chk($sformatf("v%0d done", idx), 64'(done), 64'd1);
      chk($sformatf("v%0d done_ready", idx), 64'(req_ready), 64'd1);
      chk($sformatf("v%0d done_valid_low", idx), 64'(mem_valid), 64'd0);
      chk($sformatf("v%0d done_no_err", idx), 64'(err), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d done_one_cycle", idx), 64'(done), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    req_data  = 32'd0;
    req_size  = 2'b00;
    mem_ready = 1'b1;

    tbl[0] = mk(32'h0000_1003, 32'hAABB_CCDD, 2'b00, 1'b0, 1,
                32'h0000_1000, 4'b1000, 32'hDD00_0000, 32'd0, 4'd0, 32'd0);
    tbl[1] = mk(32'h0000_2002, 32'h1234_5678, 2'b01, 1'b0, 1,
                32'h0000_2000, 4'b1100, 32'h5678_0000, 32'd0, 4'd0, 32'd0);
    tbl[2] = mk_err(32'h0000_0100, 32'h1111_1111, 2'b11);
    tbl[3] = mk(32'h0000_4000, 32'hDEAD_BEEF, 2'b10, 1'b0, 1,
                32'h0000_4000, 4'b1111, 32'hDEAD_BEEF, 32'd0, 4'd0, 32'd0);
    tbl[4] = mk(32'h0000_5000, 32'h1234_56A5, 2'b00, 1'b0, 1,
                32'h0000_5000, 4'b0001, 32'h0000_00A5, 32'd0, 4'd0, 32'd0);
    tbl[5] = mk(32'h0000_8001, 32'h0000_0077, 2'b00, 1'b0, 1,
                32'h0000_8000, 4'b0010, 32'h0000_7700, 32'd0, 4'd0, 32'd0);
`ifdef MISALIGN_SPLIT_EN
    tbl[6] = mk(32'h0000_3001, 32'h1122_3344, 2'b10, 1'b0, 2,
                32'h0000_3000, 4'b1110, 32'h2233_4400, 32'h0000_3004, 4'b0001, 32'h0000_0011);
    tbl[7] = mk(32'hFFFF_FFFE, 32'hCAFE_BABE, 2'b10, 1'b0, 2,
                32'hFFFF_FFFC, 4'b1100, 32'hBABE_0000, 32'h0000_0000, 4'b0011, 32'h0000_CAFE);
    tbl[8] = mk(32'h0000_6001, 32'hFFFF_8001, 2'b01, 1'b0, 1,
                32'h0000_6000, 4'b0110, 32'h0080_0100, 32'd0, 4'd0, 32'd0);
    tbl[9] = mk(32'h0000_7003, 32'h0000_BEEF, 2'b01, 1'b0, 2,
                32'h0000_7000, 4'b1000, 32'hEF00_0000, 32'h0000_7004, 4'b0001, 32'h0000_00BE);
`else
    tbl[6] = mk_err(32'h0000_3001, 32'h1122_3344, 2'b10);
    tbl[7] = mk_err(32'hFFFF_FFFE, 32'hCAFE_BABE, 2'b10);
    tbl[8] = mk_err(32'h0000_6001, 32'hFFFF_8001, 2'b01);
    tbl[9] = mk_err(32'h0000_7003, 32'h0000_BEEF, 2'b01);
`endif

    // Reset state
    #12;
    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk("rst mem_valid", 64'(mem_valid), 64'd0);
    chk("rst mem_addr", 64'(mem_addr), 64'd0);
    chk("rst mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst mem_be", 64'(mem_be), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Backpressure in BEAT0: outputs stable for 5 stalled cycles, new requests ignored
    @(negedge clk);
    mem_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0000_9000;
    req_data  = 32'h0102_0304;
    req_size  = 2'b10;
    @(posedge clk);
    #1 req_addr = 32'h0000_A001;
    req_data = 32'hFFFF_FFFF;
    req_size = 2'b00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d valid", c), 64'(mem_valid), 64'd1);
      chk($sformatf("bp%0d addr", c), 64'(mem_addr), 64'h0000_9000);
      chk($sformatf("bp%0d wdata", c), 64'(mem_wdata), 64'h0102_0304);
      chk($sformatf("bp%0d be", c), 64'(mem_be), 64'hF);
      chk($sformatf("bp%0d req_ready", c), 64'(req_ready), 64'd0);
      chk($sformatf("bp%0d no_done", c), 64'(done), 64'd0);
    end
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("bp done", 64'(done), 64'd1);
    chk("bp done_ready", 64'(req_ready), 64'd1);
    chk("bp valid_low", 64'(mem_valid), 64'd0);
    @(negedge clk);
    chk("bp done_one_cycle", 64'(done), 64'd0);
    chk("bp no_second_store", 64'(mem_valid), 64'd0);

    // Reset in the middle of an access (BEAT1 with split, BEAT0 otherwise)
    @(negedge clk);
    req_valid = 1'b1;
`ifdef MISALIGN_SPLIT_EN
    req_addr  = 32'h0000_3001;
`else
    req_addr  = 32'h0000_3000;
`endif
    req_data  = 32'h1122_3344;
    req_size  = 2'b10;
    @(posedge clk);
    #1 req_valid = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    chk("mrst beat1 be", 64'(mem_be), 64'h1);
    chk("mrst beat1 addr", 64'(mem_addr), 64'h0000_3004);
`else
    mem_ready = 1'b0;
    @(negedge clk);
    chk("mrst beat0 be", 64'(mem_be), 64'hF);
`endif
    chk("mrst pre valid", 64'(mem_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst async valid", 64'(mem_valid), 64'd0);
    chk("mrst async be", 64'(mem_be), 64'd0);
    chk("mrst async ready", 64'(req_ready), 64'd1);
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mrst%0d no_done", c), 64'(done), 64'd0);
      chk($sformatf("mrst%0d no_valid", c), 64'(mem_valid), 64'd0);
    end
    run_vec(tbl[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
